alu_op_sequencer: RTL and testbench

ALU_OP_SEQUENCER -- requirements
Module: alu_op_sequencer

---
 rtl/alu_pkg.sv | 27 ++
 rtl/div5_serial.sv | 57 +++++
 rtl/alu_op_sequencer.sv | 146 ++++++++++++++
 tb/tb_alu_op_sequencer.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared widths, opcodes and FSM states
// for the ALU op sequencer.
package alu_pkg;

  localparam int OPW  = 5;
  localparam int IMMW = 16;
  localparam int YW   = 17;
  localparam int CTW  = 6;

  localparam logic [CTW-1:0] OP_AND  = 6'h00;
  localparam logic [CTW-1:0] OP_OR   = 6'h01;
  localparam logic [CTW-1:0] OP_NOT  = 6'h02;
  localparam logic [CTW-1:0] OP_MUL  = 6'h03;
  localparam logic [CTW-1:0] OP_DIV  = 6'h04;
  localparam logic [CTW-1:0] OP_SHR  = 6'h05;
  localparam logic [CTW-1:0] OP_SHL  = 6'h06;
  localparam logic [CTW-1:0] OP_ADDI = 6'h0A;
  localparam logic [CTW-1:0] OP_SUBI = 6'h0B;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXEC,
    ST_DIV_RUN,
    ST_DONE
  } state_t;

endpackage

// File: rtl/div5_serial.sv
// Restoring 5-bit unsigned divider, one
// quotient bit per cycle, MSB first.
module div5_serial
  import alu_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [OPW-1:0] a,
  input  logic [OPW-1:0] b,
  output logic           done,
  output logic [OPW-1:0] quotient,
  output logic [OPW-1:0] remainder
);

  logic [OPW-1:0] q;
  logic [OPW-1:0] r;
  logic [2:0]     cnt;
  logic [OPW:0]   r_sh;
  logic [OPW:0]   r_dif;
  logic           ge;
  logic [OPW-1:0] q_nxt;
  logic [OPW-1:0] r_nxt;

  // one restoring step; done/outputs show
  // the values this edge will commit
  always_comb begin
    r_sh  = {r, q[OPW-1]};
    r_dif = r_sh - {1'b0, b};
    ge    = (r_sh >= {1'b0, b});
    r_nxt = ge ? r_dif[OPW-1:0]
               : r_sh[OPW-1:0];
    q_nxt = {q[OPW-2:0], ge};
    done      = (cnt == 3'd1);
    quotient  = q_nxt;
    remainder = r_nxt;
  end

  // iteration state: load on start, then
  // shift/subtract until count reaches 0
  always_ff @(posedge clk) begin
    if (rst) begin
      q   <= '0;
      r   <= '0;
      cnt <= '0;
    end else if (start) begin
      q   <= a;
      r   <= '0;
      cnt <= 3'd5;
    end else if (cnt != 3'd0) begin
      q   <= q_nxt;
      r   <= r_nxt;
      cnt <= cnt - 3'd1;
    end
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// Handshaked ALU op sequencer: captures a
// request, executes it, holds the result.
module alu_op_sequencer
  import alu_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [CTW-1:0]  in_ctrl,
  input  logic [OPW-1:0]  in_a,
  input  logic [OPW-1:0]  in_b,
  input  logic [OPW-1:0]  in_shift,
  input  logic [IMMW-1:0] in_imm,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [YW-1:0]   out_y,
  output logic [OPW-1:0]  out_rem,
  output logic            out_err,
  output logic            busy
);

  state_t          state;
  logic [CTW-1:0]  rop;
  logic [OPW-1:0]  ra;
  logic [OPW-1:0]  rb;
  logic [OPW-1:0]  rs;
  logic [IMMW-1:0] rimm;

  logic [YW-1:0]   alu_y;
  logic [OPW-1:0]  alu_rem;
  logic            alu_err;
  logic            is_div;
  logic            div_start;
  logic            div_done;
  logic [OPW-1:0]  div_q;
  logic [OPW-1:0]  div_r;
  logic            accept;

  // handshake and divider launch
  always_comb begin
    in_ready = ~rst & (
      (state == ST_IDLE) |
      ((state == ST_DONE) & out_ready));
    accept    = in_valid & in_ready;
    busy      = (state != ST_IDLE);
    is_div    = (rop == OP_DIV);
    div_start = (state == ST_EXEC) & is_div
              & (rb != '0);
  end

  // single-cycle ops from registered inputs
  always_comb begin
    alu_y   = '0;
    alu_rem = '0;
    alu_err = 1'b0;
    unique case (rop)
      OP_AND:  alu_y = {12'b0, ra & rb};
      OP_OR:   alu_y = {12'b0, ra | rb};
      OP_NOT:  alu_y = {12'b0, ~ra};
      OP_MUL:  alu_y = {7'b0,
                 {5'b0, ra} * {5'b0, rb}};
      OP_DIV: begin
        alu_y   = 17'h0001F;
        alu_rem = ra;
        alu_err = 1'b1;
      end
      OP_SHR:  alu_y = {12'b0, ra >> rs};
      OP_SHL:  alu_y = {12'b0, ra} << rs;
      OP_ADDI: alu_y = {12'b0, ra}
                     + {1'b0, rimm};
      OP_SUBI: alu_y = {12'b0, ra}
                     - {1'b0, rimm};
      default: alu_err = 1'b1;
    endcase
  end

  div5_serial u_div (
    .clk       (clk),
    .rst       (rst),
    .start     (div_start),
    .a         (ra),
    .b         (rb),
    .done      (div_done),
    .quotient  (div_q),
    .remainder (div_r)
  );

  // control FSM with registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      rop       <= '0;
      ra        <= '0;
      rb        <= '0;
      rs        <= '0;
      rimm      <= '0;
      out_valid <= 1'b0;
      out_y     <= '0;
      out_rem   <= '0;
      out_err   <= 1'b0;
    end else begin
      if (accept) begin
        rop  <= in_ctrl;
        ra   <= in_a;
        rb   <= in_b;
        rs   <= in_shift;
        rimm <= in_imm;
      end
      unique case (state)
        ST_IDLE: begin
          if (accept) state <= ST_EXEC;
        end
        ST_EXEC: begin
          if (div_start) begin
            state <= ST_DIV_RUN;
          end else begin
            state     <= ST_DONE;
            out_valid <= 1'b1;
            out_y     <= alu_y;
            out_rem   <= alu_rem;
            out_err   <= alu_err;
          end
        end
        ST_DIV_RUN: begin
          if (div_done) begin
            state     <= ST_DONE;
            out_valid <= 1'b1;
            out_y     <= {12'b0, div_q};
            out_rem   <= div_r;
            out_err   <= 1'b0;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state <= accept ? ST_EXEC
                            : ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed, table-driven bench for
// alu_op_sequencer.
module tb_alu_op_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [5:0]  in_ctrl;
  logic [4:0]  in_a;
  logic [4:0]  in_b;
  logic [4:0]  in_shift;
  logic [15:0] in_imm;
  logic        out_valid;
  logic        out_ready;
  logic [16:0] out_y;
  logic [4:0]  out_rem;
  logic        out_err;
  logic        busy;

  int nchecks = 0;
  int nerrors = 0;

  always #5 clk = ~clk;

  alu_op_sequencer dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_ctrl   (in_ctrl),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_shift  (in_shift),
    .in_imm    (in_imm),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_y     (out_y),
    .out_rem   (out_rem),
    .out_err   (out_err),
    .busy      (busy)
  );

  typedef struct {
    logic [5:0]  ctrl;
    logic [4:0]  a;
    logic [4:0]  b;
    logic [4:0]  sh;
    logic [15:0] imm;
    logic [16:0] y;
    logic [4:0]  rem;
    logic        err;
    int          lat;
  } vec_t;

  vec_t vecs[16];

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerrors++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  function automatic vec_t mk(
    input logic [5:0] c, input logic [4:0] a,
    input logic [4:0] b, input logic [4:0] s,
    input logic [15:0] i, input logic [16:0] y,
    input logic [4:0] r, input logic e,
    input int l);
    vec_t v;
    v.ctrl = c; v.a = a; v.b = b; v.sh = s;
    v.imm = i; v.y = y; v.rem = r; v.err = e;
    v.lat = l;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    in_ctrl  = v.ctrl;
    in_a     = v.a;
    in_b     = v.b;
    in_shift = v.sh;
    in_imm   = v.imm;
    in_valid = 1'b1;
  endtask

  // present request, wait for result, check,
  // leave out_ready=1 so it is consumed
  task automatic apply(input vec_t v,
                       input string tag);
    int lat;
    logic busy_ok;
    bit seen;
    @(negedge clk);
    out_ready = 1'b1;
    drive(v);
    seen = 0;
    for (int k = 0; k < 20 && !seen; k++) begin
      if (in_ready) seen = 1;
      else @(negedge clk);
    end
    chk({tag, " accept"}, {31'b0, seen}, 1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    busy_ok = 1'b1;
    seen = 0;
    for (int k = 0; k < 30 && !seen; k++) begin
      if (!busy) busy_ok = 1'b0;
      if (out_valid) seen = 1;
      else begin
        lat++;
        @(negedge clk);
      end
    end
    chk({tag, " valid"}, {31'b0, seen}, 1);
    chk({tag, " lat"}, lat, v.lat);
    chk({tag, " busy"}, {31'b0, busy_ok}, 1);
    chk({tag, " y"}, {15'b0, out_y}, {15'b0, v.y});
    chk({tag, " rem"}, {27'b0, out_rem},
        {27'b0, v.rem});
    chk({tag, " err"}, {31'b0, out_err},
        {31'b0, v.err});
  endtask

  initial begin
    vecs[0]  = mk(6'h00, 5'h15, 5'h0F, 0, 0,
                  17'h05, 0, 0, 2);
    vecs[1]  = mk(6'h01, 5'h10, 5'h03, 0, 0,
                  17'h13, 0, 0, 2);
    vecs[2]  = mk(6'h02, 5'h0A, 5'h00, 0, 0,
                  17'h15, 0, 0, 2);
    vecs[3]  = mk(6'h03, 5'd31, 5'd31, 0, 0,
                  17'd961, 0, 0, 2);
    vecs[4]  = mk(6'h04, 5'd23, 5'd5, 0, 0,
                  17'd4, 5'd3, 0, 7);
    vecs[5]  = mk(6'h04, 5'd9, 5'd0, 0, 0,
                  17'h1F, 5'd9, 1, 2);
    vecs[6]  = mk(6'h04, 5'd31, 5'd1, 0, 0,
                  17'd31, 5'd0, 0, 7);
    vecs[7]  = mk(6'h04, 5'd4, 5'd31, 0, 0,
                  17'd0, 5'd4, 0, 7);
    vecs[8]  = mk(6'h05, 5'h18, 0, 5'd3, 0,
                  17'h3, 0, 0, 2);
    vecs[9]  = mk(6'h06, 5'd1, 0, 5'd16, 0,
                  17'h10000, 0, 0, 2);
    vecs[10] = mk(6'h06, 5'd31, 0, 5'd17, 0,
                  17'h0, 0, 0, 2);
    vecs[11] = mk(6'h06, 5'd31, 0, 5'd12, 0,
                  17'h1F000, 0, 0, 2);
    vecs[12] = mk(6'h0A, 5'd31, 0, 0, 16'hFFFF,
                  17'h1001E, 0, 0, 2);
    vecs[13] = mk(6'h0B, 5'd2, 0, 0, 16'h3,
                  17'h1FFFF, 0, 0, 2);
    vecs[14] = mk(6'h07, 5'd3, 5'd3, 0, 0,
                  17'h0, 0, 1, 2);
    vecs[15] = mk(6'h3F, 5'd7, 5'd1, 0, 0,
                  17'h0, 0, 1, 2);

    rst = 1'b1;
    out_ready = 1'b0;
    drive(vecs[0]);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst in_ready", {31'b0, in_ready}, 0);
    chk("rst out_valid", {31'b0, out_valid}, 0);
    chk("rst busy", {31'b0, busy}, 0);
    chk("rst out_y", {15'b0, out_y}, 0);
    rst = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("post-rst in_ready", {31'b0, in_ready}, 1);

    for (int i = 0; i < 16; i++)
      apply(vecs[i], $sformatf("vec%0d", i));

    // back-to-back MUL then SUBI
    @(negedge clk);
    out_ready = 1'b1;
    drive(vecs[3]);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    chk("b2b mul valid", {31'b0, out_valid}, 1);
    chk("b2b mul y", {15'b0, out_y}, 961);
    chk("b2b done in_ready", {31'b0, in_ready}, 1);
    drive(vecs[13]);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    chk("b2b exec busy", {31'b0, busy}, 1);
    chk("b2b exec valid", {31'b0, out_valid}, 0);
    @(negedge clk);
    chk("b2b subi valid", {31'b0, out_valid}, 1);
    chk("b2b subi y", {15'b0, out_y}, 32'h1FFFF);
    @(negedge clk);
    chk("b2b idle busy", {31'b0, busy}, 0);

    // backpressure on SHL 1<<16
    out_ready = 1'b0;
    drive(vecs[9]);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      chk("bp valid", {31'b0, out_valid}, 1);
      chk("bp y", {15'b0, out_y}, 32'h10000);
      chk("bp in_ready", {31'b0, in_ready}, 0);
      if (k < 3) @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp release busy", {31'b0, busy}, 0);
    chk("bp release valid", {31'b0, out_valid}, 0);
    chk("bp release in_ready", {31'b0, in_ready}, 1);

    // reset on 3rd DIV_RUN cycle
    drive(vecs[4]);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("div mid busy", {31'b0, busy}, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("div rst valid", {31'b0, out_valid}, 0);
    chk("div rst busy", {31'b0, busy}, 0);
    chk("div rst in_ready", {31'b0, in_ready}, 0);
    rst = 1'b0;
    #1;
    chk("div rst idle", {31'b0, in_ready}, 1);
    apply(vecs[14], "post-rst illegal");
    apply(vecs[4], "post-rst div");

    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors",
             nchecks, nerrors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
